// File: rtl/onehot_bcd_encoder.sv
// onehot_bcd_encoder
//   Accepts an N_IN-bit one-hot word, resolves the index of the set bit and
//   converts it to packed BCD with a double-dabble engine that performs one
//   shift per clock. Zero-hot and multi-hot codes are flagged through err and
//   produce all-F nibbles.
//
// Optional feature (compile-time macro): ONEHOT_PRIORITY_EN
//   defined   : multi-hot words resolve to the lowest set bit and convert
//               normally (err=0). A zero-hot word is still an error.
//   undefined : multi-hot words are errors, exactly like zero-hot.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input word valid
//   in_ready   block can accept (IDLE only, low while rst is high)
//   in         one-hot code, bit k means decimal value k
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   out        packed BCD, most significant digit in the top nibble
//   err        result came from an invalid code, qualified by out_valid
//   dbg_state  current FSM state (0 IDLE, 1 CONV, 2 DONE) for observation
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds data stable while valid is high and ready is low;
// ready never depends combinationally on the partner's valid.
module onehot_bcd_encoder #(
  parameter int N_IN   = 10,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN-1:0]       in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(IDX_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [BW-1:0]      bcd;
  logic [CNT_W-1:0]   cnt;
  logic               bad;

  // Input classification
  logic               zero_hot;
  logic               multi_hot;
  logic               accept_bad;
  logic [IDX_W-1:0]   low_idx;

  assign zero_hot  = (in == '0);
  // Clearing the lowest set bit leaves something behind only if >1 bit is set.
  assign multi_hot = |(in & (in - {{(N_IN-1){1'b0}}, 1'b1}));

`ifdef ONEHOT_PRIORITY_EN
  assign accept_bad = zero_hot;
`else
  assign accept_bad = zero_hot | multi_hot;
`endif

  // Lowest set bit index: scanning downward lets the lowest bit win.
  always_comb begin
    low_idx = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (in[k]) low_idx = IDX_W'(k);
    end
  end

  // One double-dabble step: adjust every nibble >= 5 by +3, then shift the
  // index MSB into the BCD LSB.
  logic [BW-1:0] bcd_adj;
  logic [BW-1:0] bcd_next;

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[BW-2:0], idx[IDX_W-1]};
  end

  // Both handshake outputs are decodes of registered state; rst only masks
  // in_ready so nothing is advertised while the block is held in reset.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  // Invalid codes pass through CONV with a zero step count so that every
  // result spends one finishing edge in CONV before DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      bad   <= 1'b0;
      out   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bcd   <= '0;
            idx   <= low_idx;
            bad   <= accept_bad;
            cnt   <= accept_bad ? '0 : CNT_W'(IDX_W);
            state <= CONV;
          end
        end
        CONV: begin
          if (cnt == '0) begin
            state <= DONE;
            if (bad) begin
              out <= {DIGITS{4'hF}};
              err <= 1'b1;
            end else begin
              out <= bcd;
              err <= 1'b0;
            end
          end else begin
            bcd <= bcd_next;
            idx <= idx << 1;
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_bcd_encoder.sv
// Bench for onehot_bcd_encoder: two instances (N_IN=10 and N_IN=16, both two
// digits) share clock and reset. Directed vectors carry hand-computed results;
// single-hot sweeps use a decimal model built from / and %.
module tb_onehot_bcd_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals (index 0: N_IN=10, 1: N_IN=16) ----------------
  logic        iv  [2];
  logic        ir  [2];
  logic [15:0] iw  [2];
  logic        ov  [2];
  logic        orr [2];
  logic [7:0]  ob  [2];
  logic        er  [2];
  logic [1:0]  dbg [2];

  onehot_bcd_encoder #(.N_IN(10), .DIGITS(2)) dut10 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]), .in(iw[0][9:0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out(ob[0]), .err(er[0]),
    .dbg_state(dbg[0])
  );

  onehot_bcd_encoder #(.N_IN(16), .DIGITS(2)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]), .in(iw[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out(ob[1]), .err(er[1]),
    .dbg_state(dbg[1])
  );

  // ---------------- scoreboard ----------------
  // entry = {due_cycle[15:0], err, out[7:0]}
  logic [24:0] exp_q0[$];
  logic [24:0] exp_q1[$];
  logic        seen [2];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int s, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, s, cyc, got, want);
    end
  endtask

  function automatic int q_size(input int s);
    return (s == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [24:0] q_front(input int s);
    return (s == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_pop(input int s);
    if (s == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic q_push(input int s, input logic [24:0] e);
    if (s == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Decimal model: two BCD digits of v.
  function automatic logic [7:0] model_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((v / 10) % 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  // Compare process: every cycle a result is presented it must match the head
  // of the expected queue, appear exactly on its due cycle, and never appear
  // when nothing is outstanding.
  task automatic mon(input int s);
    logic [24:0] e;
    if (rst) begin
      if (s == 0) exp_q0.delete(); else exp_q1.delete();
      seen[s] = 1'b0;
    end else if (ov[s] === 1'b1) begin
      if (q_size(s) == 0) begin
        chk("spurious_valid", s, 32'(ov[s]), 32'd0);
      end else begin
        e = q_front(s);
        chk("out", s, 32'(ob[s]), 32'(e[7:0]));
        chk("err", s, 32'(er[s]), 32'(e[8]));
        if (!seen[s]) chk("latency", s, 32'(cyc), 32'(e[24:9]));
        seen[s] = 1'b1;
        if (orr[s]) begin
          q_pop(s);
          seen[s] = 1'b0;
        end
      end
    end else if (q_size(s) > 0 && !seen[s]) begin
      e = q_front(s);
      if (cyc >= int'(e[24:9])) begin
        chk("late_valid", s, 32'(ov[s]), 32'd1);
        q_pop(s);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int s, input logic [15:0] w, input logic [7:0] eo,
                      input logic ee, input int lat);
    int n;
    n = 0;
    @(posedge clk); #1;
    iw[s] = w;
    iv[s] = 1'b1;
    @(negedge clk);
    while (ir[s] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ir[s] !== 1'b1) begin
      chk("accept_timeout", s, 32'(ir[s]), 32'd1);
    end else begin
      q_push(s, {16'(cyc + 1 + lat), ee, eo});
    end
    @(posedge clk); #1;
    iv[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s);
    int n;
    n = 0;
    while (q_size(s) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q_size(s) != 0) chk("drain_timeout", s, 32'(q_size(s)), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] m_out;
    logic       m_err;
    int         m_lat;
    int         n;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; iw[s] = '0; orr[s] = 1'b1; seen[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_in_ready", s, 32'(ir[s]), 32'd0);
      chk("rst_out_valid", s, 32'(ov[s]), 32'd0);
      chk("rst_out", s, 32'(ob[s]), 32'd0);
      chk("rst_err", s, 32'(er[s]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) chk("post_rst_in_ready", s, 32'(ir[s]), 32'd1);

    // Directed vectors, N_IN=10
    send(0, 16'b0000000001, 8'h00, 1'b0, 5);
    send(0, 16'b1000000000, 8'h09, 1'b0, 5);
    send(0, 16'b0000100000, 8'h05, 1'b0, 5);
    send(0, 16'b0000000000, 8'hFF, 1'b1, 1);
`ifdef ONEHOT_PRIORITY_EN
    send(0, 16'b0000100100, 8'h02, 1'b0, 5);
`else
    send(0, 16'b0000100100, 8'hFF, 1'b1, 1);
`endif
    wait_idle(0);

    // Directed vectors, N_IN=16
    send(1, 16'h2000, 8'h13, 1'b0, 5);
    send(1, 16'h8000, 8'h15, 1'b0, 5);
    send(1, 16'h0400, 8'h10, 1'b0, 5);
    send(1, 16'h0000, 8'hFF, 1'b1, 1);
`ifdef ONEHOT_PRIORITY_EN
    send(1, 16'h8010, 8'h04, 1'b0, 5);
`else
    send(1, 16'h8010, 8'hFF, 1'b1, 1);
`endif
    wait_idle(1);

    // Single-hot sweeps against the decimal model
    for (int k = 0; k < 10; k++) send(0, 16'(1) << k, model_bcd(k), 1'b0, 5);
    for (int k = 0; k < 16; k++) send(1, 16'(1) << k, model_bcd(k), 1'b0, 5);
    wait_idle(0);
    wait_idle(1);

    // A random multi-hot word on the wide instance
    iw[1] = 16'(($urandom_range(1, 255) << 4) | 16'h0008);
`ifdef ONEHOT_PRIORITY_EN
    m_out = 8'h03; m_err = 1'b0; m_lat = 5;
`else
    m_out = 8'hFF; m_err = 1'b1; m_lat = 1;
`endif
    send(1, iw[1], m_out, m_err, m_lat);
    wait_idle(1);

    // Back-pressure: result held while out_ready is low, input ignored
    orr[0] = 1'b0;
    send(0, 16'b0010000000, 8'h07, 1'b0, 5);
    n = 0;
    @(negedge clk);
    while (ov[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", 0, 32'(ov[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      iv[0] = (i == 1);
      iw[0] = 16'b0000001000;
      @(negedge clk);
      chk("bp_in_ready", 0, 32'(ir[0]), 32'd0);
      chk("bp_hold_valid", 0, 32'(ov[0]), 32'd1);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    orr[0] = 1'b1;
    @(negedge clk);   // handoff presented here, taken on the next edge
    @(negedge clk);
    chk("handoff_in_ready", 0, 32'(ir[0]), 32'd1);
    chk("handoff_out_valid", 0, 32'(ov[0]), 32'd0);

    // Reset in the middle of a conversion: no result may appear
    @(posedge clk); #1;
    iw[0] = 16'b0100000000;
    iv[0] = 1'b1;
    @(negedge clk);
    chk("abort_accept_ready", 0, 32'(ir[0]), 32'd1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_in_ready", 0, 32'(ir[0]), 32'd0);
    chk("abort_rst_out_valid", 0, 32'(ov[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 0, 32'(ir[0]), 32'd1);
    chk("abort_out", 0, 32'(ob[0]), 32'd0);
    chk("abort_err", 0, 32'(er[0]), 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_no_valid", 0, 32'(ov[0]), 32'd0);

    // Conversion still works after the abort
    send(0, 16'b0100000000, 8'h08, 1'b0, 5);
    wait_idle(0);

    repeat (4) @(negedge clk);
    chk("final_q0_empty", 0, 32'(exp_q0.size()), 32'd0);
    chk("final_q1_empty", 1, 32'(exp_q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global bound on run time
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
